// File: rtl/peripheral_spram_axi4_master_if.sv
// AXI4 bus between the single-beat SPRAM master and the peripheral_spram_axi4 slave.
// Field widths match the slave so the two connect directly.
interface peripheral_spram_axi4_master_if #(
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_STRB_WIDTH = 8,
   parameter int AXI_USER_WIDTH = 10
);
   logic [AXI_ID_WIDTH-1:0]   axi_aw_id;
   logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr;
   logic [7:0]                axi_aw_len;
   logic [2:0]                axi_aw_size;
   logic [1:0]                axi_aw_burst;
   logic                      axi_aw_lock;
   logic [3:0]                axi_aw_cache;
   logic [2:0]                axi_aw_prot;
   logic [3:0]                axi_aw_qos;
   logic [3:0]                axi_aw_region;
   logic [AXI_USER_WIDTH-1:0] axi_aw_user;
   logic                      axi_aw_valid;
   logic                      axi_aw_ready;

   logic [AXI_DATA_WIDTH-1:0] axi_w_data;
   logic [AXI_STRB_WIDTH-1:0] axi_w_strb;
   logic                      axi_w_last;
   logic [AXI_USER_WIDTH-1:0] axi_w_user;
   logic                      axi_w_valid;
   logic                      axi_w_ready;

   logic [AXI_ID_WIDTH-1:0]   axi_b_id;
   logic [1:0]                axi_b_resp;
   logic [AXI_USER_WIDTH-1:0] axi_b_user;
   logic                      axi_b_valid;
   logic                      axi_b_ready;

   logic [AXI_ID_WIDTH-1:0]   axi_ar_id;
   logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr;
   logic [7:0]                axi_ar_len;
   logic [2:0]                axi_ar_size;
   logic [1:0]                axi_ar_burst;
   logic                      axi_ar_lock;
   logic [3:0]                axi_ar_cache;
   logic [2:0]                axi_ar_prot;
   logic [3:0]                axi_ar_qos;
   logic [3:0]                axi_ar_region;
   logic [AXI_USER_WIDTH-1:0] axi_ar_user;
   logic                      axi_ar_valid;
   logic                      axi_ar_ready;

   logic [AXI_ID_WIDTH-1:0]   axi_r_id;
   logic [AXI_DATA_WIDTH-1:0] axi_r_data;
   logic [1:0]                axi_r_resp;
   logic                      axi_r_last;
   logic [AXI_USER_WIDTH-1:0] axi_r_user;
   logic                      axi_r_valid;
   logic                      axi_r_ready;

   modport master (
      output axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst, axi_aw_lock,
             axi_aw_cache, axi_aw_prot, axi_aw_qos, axi_aw_region, axi_aw_user, axi_aw_valid,
      input  axi_aw_ready,
      output axi_w_data, axi_w_strb, axi_w_last, axi_w_user, axi_w_valid,
      input  axi_w_ready,
      input  axi_b_id, axi_b_resp, axi_b_user, axi_b_valid,
      output axi_b_ready,
      output axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_lock,
             axi_ar_cache, axi_ar_prot, axi_ar_qos, axi_ar_region, axi_ar_user, axi_ar_valid,
      input  axi_ar_ready,
      input  axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_user, axi_r_valid,
      output axi_r_ready
   );

   modport slave (
      input  axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst, axi_aw_lock,
             axi_aw_cache, axi_aw_prot, axi_aw_qos, axi_aw_region, axi_aw_user, axi_aw_valid,
      output axi_aw_ready,
      input  axi_w_data, axi_w_strb, axi_w_last, axi_w_user, axi_w_valid,
      output axi_w_ready,
      output axi_b_id, axi_b_resp, axi_b_user, axi_b_valid,
      input  axi_b_ready,
      input  axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_lock,
             axi_ar_cache, axi_ar_prot, axi_ar_qos, axi_ar_region, axi_ar_user, axi_ar_valid,
      output axi_ar_ready,
      output axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_user, axi_r_valid,
      input  axi_r_ready
   );
endinterface

// File: rtl/peripheral_spram_axi4_master.sv
// Single-beat AXI4 master: turns one request/response transaction at a time
// into an AW/W/B write or an AR/R read toward the SPRAM slave.
module peripheral_spram_axi4_master #(
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_STRB_WIDTH = 8,
   parameter int AXI_USER_WIDTH = 10,
   parameter logic [AXI_ID_WIDTH-1:0] MASTER_ID = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
   input  logic [AXI_STRB_WIDTH-1:0] req_strb,
   output logic                      rsp_valid,
   output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
   output logic                      rsp_err,
   peripheral_spram_axi4_master_if.master axi
);

   localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_STRB_WIDTH));

   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_e;

   state_e                    state_q, state_d;
   logic                      aw_valid_q, aw_valid_d;
   logic                      w_valid_q, w_valid_d;
   logic                      ar_valid_q, ar_valid_d;
   logic                      b_ready_q, b_ready_d;
   logic                      r_ready_q, r_ready_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_err_q, rsp_err_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [AXI_STRB_WIDTH-1:0] strb_q, strb_d;
   logic                      aw_done, w_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         b_ready_q   <= 1'b0;
         r_ready_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
      end else begin
         state_q     <= state_d;
         aw_valid_q  <= aw_valid_d;
         w_valid_q   <= w_valid_d;
         ar_valid_q  <= ar_valid_d;
         b_ready_q   <= b_ready_d;
         r_ready_q   <= r_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         strb_q      <= strb_d;
      end
   end

   // A write channel counts as done once its valid has dropped or its handshake is happening now.
   always_comb begin
      state_d     = state_q;
      aw_valid_d  = aw_valid_q;
      w_valid_d   = w_valid_q;
      ar_valid_d  = ar_valid_q;
      b_ready_d   = b_ready_q;
      r_ready_d   = r_ready_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rdata_d     = rdata_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      strb_d      = strb_q;
      aw_done     = !aw_valid_q || axi.axi_aw_ready;
      w_done      = !w_valid_q || axi.axi_w_ready;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d = req_addr;
               if (req_we) begin
                  wdata_d    = req_wdata;
                  strb_d     = req_strb;
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
                  state_d    = WR;
               end else begin
                  ar_valid_d = 1'b1;
                  state_d    = RD_ADDR;
               end
            end
         end
         WR: begin
            if (aw_valid_q && axi.axi_aw_ready) aw_valid_d = 1'b0;
            if (w_valid_q && axi.axi_w_ready) w_valid_d = 1'b0;
            if (aw_done && w_done) begin
               b_ready_d = 1'b1;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: begin
            if (axi.axi_b_valid) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = axi.axi_b_resp[1];
               b_ready_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         RD_ADDR: begin
            if (axi.axi_ar_ready) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = RD_DATA;
            end
         end
         RD_DATA: begin
            if (axi.axi_r_valid) begin
               rdata_d     = axi.axi_r_data;
               rsp_err_d   = axi.axi_r_resp[1] | ~axi.axi_r_last;
               rsp_valid_d = 1'b1;
               r_ready_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rdata_q;

   assign axi.axi_aw_id     = MASTER_ID;
   assign axi.axi_aw_addr   = addr_q;
   assign axi.axi_aw_len    = 8'd0;
   assign axi.axi_aw_size   = AXI_SIZE;
   assign axi.axi_aw_burst  = 2'b01;
   assign axi.axi_aw_lock   = 1'b0;
   assign axi.axi_aw_cache  = 4'd0;
   assign axi.axi_aw_prot   = 3'd0;
   assign axi.axi_aw_qos    = 4'd0;
   assign axi.axi_aw_region = 4'd0;
   assign axi.axi_aw_user   = '0;
   assign axi.axi_aw_valid  = aw_valid_q;

   assign axi.axi_w_data    = wdata_q;
   assign axi.axi_w_strb    = strb_q;
   assign axi.axi_w_last    = 1'b1;
   assign axi.axi_w_user    = '0;
   assign axi.axi_w_valid   = w_valid_q;

   assign axi.axi_b_ready   = b_ready_q;

   assign axi.axi_ar_id     = MASTER_ID;
   assign axi.axi_ar_addr   = addr_q;
   assign axi.axi_ar_len    = 8'd0;
   assign axi.axi_ar_size   = AXI_SIZE;
   assign axi.axi_ar_burst  = 2'b01;
   assign axi.axi_ar_lock   = 1'b0;
   assign axi.axi_ar_cache  = 4'd0;
   assign axi.axi_ar_prot   = 3'd0;
   assign axi.axi_ar_qos    = 4'd0;
   assign axi.axi_ar_region = 4'd0;
   assign axi.axi_ar_user   = '0;
   assign axi.axi_ar_valid  = ar_valid_q;

   assign axi.axi_r_ready   = r_ready_q;

endmodule

// File: tb/tb_peripheral_spram_axi4_master.sv
// Randomised scoreboard bench: a behavioural slave with programmable stalls and
// responses sits on the AXI side; a reference memory predicts every response.
module tb_peripheral_spram_axi4_master;
   localparam int ID_W   = 10;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int STRB_W = 8;
   localparam int USER_W = 10;

   typedef struct {
      int         aw_delay;
      int         w_delay;
      int         ar_delay;
      int         b_delay;
      int         r_delay;
      logic [1:0] resp;
      bit         last;
   } plan_t;

   typedef struct {
      bit              we;
      logic [DATA_W-1:0] rdata;
      bit              err;
   } exp_t;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic [STRB_W-1:0] req_strb = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   plan_t             plan_q[$];
   exp_t              exp_q[$];
   logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] slave_mem[logic [ADDR_W-1:0]];
   int                checks = 0;
   int                passed = 0;
   int                aw_cycles = 0;
   int                w_cycles = 0;
   int                b_count = 0;
   int                rsp_count = 0;
   int                issued = 0;

   peripheral_spram_axi4_master_if #(
      .AXI_ID_WIDTH(ID_W), .AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W),
      .AXI_STRB_WIDTH(STRB_W), .AXI_USER_WIDTH(USER_W)
   ) axi ();

   peripheral_spram_axi4_master #(
      .AXI_ID_WIDTH(ID_W), .AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W),
      .AXI_STRB_WIDTH(STRB_W), .AXI_USER_WIDTH(USER_W), .MASTER_ID('0)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .axi(axi)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] old_d,
                                                     input logic [DATA_W-1:0] new_d,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] m;
      m = old_d;
      for (int i = 0; i < STRB_W; i++) if (strb[i]) m[8*i +: 8] = new_d[8*i +: 8];
      return m;
   endfunction

   function automatic plan_t zeroPlan();
      plan_t p;
      p.aw_delay = 0; p.w_delay = 0; p.ar_delay = 0; p.b_delay = 0; p.r_delay = 0;
      p.resp = 2'b00; p.last = 1'b1;
      return p;
   endfunction

   task automatic slaveIdle();
      axi.axi_aw_ready = 1'b0; axi.axi_w_ready = 1'b0; axi.axi_ar_ready = 1'b0;
      axi.axi_b_valid = 1'b0; axi.axi_b_resp = 2'b00; axi.axi_b_id = '0; axi.axi_b_user = '0;
      axi.axi_r_valid = 1'b0; axi.axi_r_resp = 2'b00; axi.axi_r_data = '0;
      axi.axi_r_last = 1'b0; axi.axi_r_id = '0; axi.axi_r_user = '0;
   endtask

   // Every call starts on the falling edge where the first write valid was seen.
   task automatic slaveWrite(input plan_t p);
      int                cyc;
      bit                aw_got, w_got, proto_ok, aw_stable;
      logic [ADDR_W-1:0] first_addr, wr_addr;
      logic [DATA_W-1:0] wr_data, old_d;
      logic [STRB_W-1:0] wr_strb;
      logic [48:0]       aw_ctl;
      logic [10:0]       w_ctl;
      cyc = 0; aw_got = 0; w_got = 0; proto_ok = 1; aw_stable = 1;
      wr_addr = '0; wr_data = '0; wr_strb = '0; aw_ctl = '0; w_ctl = '0;
      aw_cycles = 0; w_cycles = 0;
      first_addr = axi.axi_aw_addr;
      checkOutput("aw_w_valid_together", {62'd0, axi.axi_aw_valid, axi.axi_w_valid}, 64'd3);
      while (!(aw_got && w_got)) begin
         if (!rst_ni) begin slaveIdle(); return; end
         if (cyc > 200) begin
            checkOutput("write_addr_data_timeout", 64'd0, 64'd1); slaveIdle(); return;
         end
         axi.axi_aw_ready = !aw_got && (cyc >= p.aw_delay);
         axi.axi_w_ready  = !w_got && (cyc >= p.w_delay);
         if (aw_got == axi.axi_aw_valid) proto_ok = 0;
         if (w_got == axi.axi_w_valid) proto_ok = 0;
         if (axi.axi_aw_valid) aw_cycles++;
         if (axi.axi_w_valid) w_cycles++;
         if (!aw_got && axi.axi_aw_addr !== first_addr) aw_stable = 0;
         if (!aw_got && axi.axi_aw_valid && axi.axi_aw_ready) begin
            aw_got  = 1;
            wr_addr = axi.axi_aw_addr;
            aw_ctl  = {axi.axi_aw_id, axi.axi_aw_len, axi.axi_aw_size, axi.axi_aw_burst,
                       axi.axi_aw_lock, axi.axi_aw_cache, axi.axi_aw_prot, axi.axi_aw_qos,
                       axi.axi_aw_region, axi.axi_aw_user};
         end
         if (!w_got && axi.axi_w_valid && axi.axi_w_ready) begin
            w_got   = 1;
            wr_data = axi.axi_w_data;
            wr_strb = axi.axi_w_strb;
            w_ctl   = {axi.axi_w_last, axi.axi_w_user};
         end
         @(negedge clk_i);
         cyc++;
      end
      if (!rst_ni) begin slaveIdle(); return; end
      axi.axi_aw_ready = 1'b0;
      axi.axi_w_ready  = 1'b0;
      if (axi.axi_aw_valid || axi.axi_w_valid) proto_ok = 0;
      checkOutput("write_valid_protocol", {63'd0, proto_ok}, 64'd1);
      checkOutput("aw_addr_stable", {63'd0, aw_stable}, 64'd1);
      checkOutput("aw_constant_fields", {15'd0, aw_ctl},
                  {15'd0, 10'd0, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 10'd0});
      checkOutput("w_last_user", {53'd0, w_ctl}, {53'd0, 1'b1, 10'd0});
      old_d = slave_mem.exists(wr_addr) ? slave_mem[wr_addr] : '0;
      slave_mem[wr_addr] = mergeBytes(old_d, wr_data, wr_strb);
      for (int i = 0; i < p.b_delay; i++) begin
         @(negedge clk_i);
         if (!rst_ni) begin slaveIdle(); return; end
      end
      axi.axi_b_valid = 1'b1;
      axi.axi_b_resp  = p.resp;
      cyc = 0;
      while (!axi.axi_b_ready) begin
         @(negedge clk_i);
         if (!rst_ni) begin slaveIdle(); return; end
         cyc++;
         if (cyc > 200) begin
            checkOutput("b_ready_timeout", 64'd0, 64'd1); slaveIdle(); return;
         end
      end
      @(negedge clk_i);
      axi.axi_b_valid = 1'b0;
      axi.axi_b_resp  = 2'b00;
      b_count++;
   endtask

   task automatic slaveRead(input plan_t p);
      int                cyc;
      bit                proto_ok, ar_stable;
      logic [ADDR_W-1:0] first_addr, rd_addr;
      logic [48:0]       ar_ctl;
      cyc = 0; proto_ok = 1; ar_stable = 1; rd_addr = '0; ar_ctl = '0;
      first_addr = axi.axi_ar_addr;
      while (1) begin
         if (!rst_ni) begin slaveIdle(); return; end
         if (cyc > 200) begin
            checkOutput("ar_handshake_timeout", 64'd0, 64'd1); slaveIdle(); return;
         end
         axi.axi_ar_ready = (cyc >= p.ar_delay);
         if (!axi.axi_ar_valid) proto_ok = 0;
         if (axi.axi_ar_addr !== first_addr) ar_stable = 0;
         if (axi.axi_ar_valid && axi.axi_ar_ready) begin
            rd_addr = axi.axi_ar_addr;
            ar_ctl  = {axi.axi_ar_id, axi.axi_ar_len, axi.axi_ar_size, axi.axi_ar_burst,
                       axi.axi_ar_lock, axi.axi_ar_cache, axi.axi_ar_prot, axi.axi_ar_qos,
                       axi.axi_ar_region, axi.axi_ar_user};
            break;
         end
         @(negedge clk_i);
         cyc++;
      end
      @(negedge clk_i);
      axi.axi_ar_ready = 1'b0;
      if (!rst_ni) begin slaveIdle(); return; end
      if (axi.axi_ar_valid) proto_ok = 0;
      checkOutput("ar_valid_protocol", {63'd0, proto_ok}, 64'd1);
      checkOutput("ar_addr_stable", {63'd0, ar_stable}, 64'd1);
      checkOutput("ar_constant_fields", {15'd0, ar_ctl},
                  {15'd0, 10'd0, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 10'd0});
      for (int i = 0; i < p.r_delay; i++) begin
         @(negedge clk_i);
         if (!rst_ni) begin slaveIdle(); return; end
      end
      axi.axi_r_valid = 1'b1;
      axi.axi_r_data  = slave_mem.exists(rd_addr) ? slave_mem[rd_addr] : '0;
      axi.axi_r_resp  = p.resp;
      axi.axi_r_last  = p.last;
      cyc = 0;
      while (!axi.axi_r_ready) begin
         @(negedge clk_i);
         if (!rst_ni) begin slaveIdle(); return; end
         cyc++;
         if (cyc > 200) begin
            checkOutput("r_ready_timeout", 64'd0, 64'd1); slaveIdle(); return;
         end
      end
      @(negedge clk_i);
      axi.axi_r_valid = 1'b0;
      axi.axi_r_data  = '0;
      axi.axi_r_resp  = 2'b00;
      axi.axi_r_last  = 1'b0;
   endtask

   initial begin
      slaveIdle();
      forever begin
         @(negedge clk_i);
         if (rst_ni && (axi.axi_aw_valid || axi.axi_w_valid || axi.axi_ar_valid)) begin
            plan_t p;
            if (plan_q.size() == 0) begin
               checkOutput("unexpected_axi_request", 64'd1, 64'd0);
               p = zeroPlan();
            end else p = plan_q.pop_front();
            if (axi.axi_ar_valid) slaveRead(p);
            else slaveWrite(p);
         end
      end
   end

   // Response monitor: pops the oldest prediction whenever a completion pulse appears.
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_ni && rsp_valid) begin
            exp_t e;
            if (exp_q.size() == 0) checkOutput("unexpected_rsp_valid", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               rsp_count++;
               checkOutput(e.we ? "write_rsp_err" : "read_rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
               if (!e.we) checkOutput("read_rsp_rdata", rsp_rdata, e.rdata);
            end
         end
      end
   end

   // Called on a falling edge; returns on the falling edge right after acceptance.
   task automatic applyStimulus(input bit we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                                input plan_t p, input bit expect_rsp, output bit rsp_at_accept);
      exp_t e;
      int   cyc;
      logic [DATA_W-1:0] old_d;
      old_d = ref_mem.exists(addr) ? ref_mem[addr] : '0;
      e.we = we;
      if (we) begin
         e.rdata = '0;
         e.err   = p.resp[1];
         if (expect_rsp) ref_mem[addr] = mergeBytes(old_d, wdata, strb);
      end else begin
         e.rdata = old_d;
         e.err   = p.resp[1] | !p.last;
      end
      plan_q.push_back(p);
      if (expect_rsp) begin
         exp_q.push_back(e);
         issued++;
      end
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_strb = strb;
      cyc = 0;
      while (!req_ready && cyc < 500) begin
         @(negedge clk_i);
         cyc++;
      end
      if (!req_ready) checkOutput("req_ready_timeout", 64'd0, 64'd1);
      rsp_at_accept = rsp_valid;
      @(negedge clk_i);
      req_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 1000) begin
         @(negedge clk_i);
         cyc++;
      end
      if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk_i);
   endtask

   initial begin
      plan_t p;
      bit    acc_rsp;
      int    b_before, cyc;
      #1;
      checkOutput("reset_valids", {58'd0, axi.axi_aw_valid, axi.axi_w_valid, axi.axi_ar_valid,
                  axi.axi_b_ready, axi.axi_r_ready, rsp_valid}, 64'd0);
      checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 64'd0);
      checkOutput("reset_aw_addr", axi.axi_aw_addr, 64'd0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      checkOutput("idle_req_ready", {63'd0, req_ready}, 64'd1);

      $display("[TB] directed write/read at 0x40");
      applyStimulus(1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF, zeroPlan(), 1'b1, acc_rsp);
      waitDrain();
      applyStimulus(1'b0, 64'h40, '0, '0, zeroPlan(), 1'b1, acc_rsp);
      waitDrain();

      $display("[TB] write with delayed aw_ready");
      p = zeroPlan();
      p.aw_delay = 3;
      b_before = b_count;
      applyStimulus(1'b1, 64'h48, 64'h0123_4567_89AB_CDEF, 8'h0F, p, 1'b1, acc_rsp);
      waitDrain();
      checkOutput("aw_valid_cycles", 64'(aw_cycles), 64'd4);
      checkOutput("w_valid_cycles", 64'(w_cycles), 64'd1);
      checkOutput("b_handshake_count", 64'(b_count - b_before), 64'd1);
      applyStimulus(1'b0, 64'h48, '0, '0, zeroPlan(), 1'b1, acc_rsp);
      waitDrain();

      $display("[TB] read error responses");
      p = zeroPlan();
      p.resp = 2'b10;
      applyStimulus(1'b0, 64'h40, '0, '0, p, 1'b1, acc_rsp);
      p = zeroPlan();
      p.last = 1'b0;
      applyStimulus(1'b0, 64'h40, '0, '0, p, 1'b1, acc_rsp);
      waitDrain();

      $display("[TB] back-to-back requests");
      p = zeroPlan();
      p.b_delay = 1;
      applyStimulus(1'b1, 64'h50, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, p, 1'b1, acc_rsp);
      applyStimulus(1'b0, 64'h50, '0, '0, zeroPlan(), 1'b1, acc_rsp);
      checkOutput("b2b_accept_during_rsp", {63'd0, acc_rsp}, 64'd1);
      applyStimulus(1'b1, 64'h58, 64'h1111_2222_3333_4444, 8'hC3, zeroPlan(), 1'b1, acc_rsp);
      checkOutput("b2b_accept_during_rsp2", {63'd0, acc_rsp}, 64'd1);
      waitDrain();

      $display("[TB] randomised traffic");
      for (int i = 0; i < 60; i++) begin
         plan_t rp;
         rp.aw_delay = $urandom_range(0, 3);
         rp.w_delay  = $urandom_range(0, 3);
         rp.ar_delay = $urandom_range(0, 3);
         rp.b_delay  = $urandom_range(0, 3);
         rp.r_delay  = $urandom_range(0, 3);
         rp.resp     = 2'($urandom_range(0, 3));
         rp.last     = ($urandom_range(0, 7) != 0);
         applyStimulus(1'($urandom_range(0, 1)), 64'h100 + 64'($urandom_range(0, 7)) * 64'd8,
                       {$urandom, $urandom}, 8'($urandom), rp, 1'b1, acc_rsp);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
      end
      waitDrain();

      $display("[TB] reset during write response wait");
      p = zeroPlan();
      p.b_delay = 10;
      applyStimulus(1'b1, 64'h9000, 64'hFFFF_0000_FFFF_0000, 8'hFF, p, 1'b0, acc_rsp);
      cyc = 0;
      while (!axi.axi_b_ready && cyc < 100) begin
         @(negedge clk_i);
         cyc++;
      end
      checkOutput("reached_write_resp", {63'd0, axi.axi_b_ready}, 64'd1);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      checkOutput("async_reset_valids", {59'd0, axi.axi_aw_valid, axi.axi_w_valid,
                  axi.axi_ar_valid, axi.axi_r_ready, rsp_valid}, 64'd0);
      checkOutput("async_reset_b_ready", {63'd0, axi.axi_b_ready}, 64'd0);
      checkOutput("async_reset_req_ready", {63'd0, req_ready}, 64'd1);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk_i);
      checkOutput("req_ready_after_reset", {63'd0, req_ready}, 64'd1);

      applyStimulus(1'b0, 64'h40, '0, '0, zeroPlan(), 1'b1, acc_rsp);
      waitDrain();
      checkOutput("response_count", 64'(rsp_count), 64'(issued));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/peripheral_spram_axi4_master.md
Name: peripheral_spram_axi4_master

Overview:
- Single-beat AXI4 master that converts a simple request/response port into AXI4 write (AW/W/B) and read (AR/R) transactions.
- Sits directly upstream of peripheral_spram_axi4 and drives its slave port; used by the MPSoC BFM layer and by the SPRAM benches as the traffic source.
- Handles one outstanding transaction at a time.

Parameters:
- AXI_ID_WIDTH, 10, width of AXI ID fields
- AXI_ADDR_WIDTH, 64, address width
- AXI_DATA_WIDTH, 64, data width
- AXI_STRB_WIDTH, 8, strobe width (AXI_DATA_WIDTH/8)
- AXI_USER_WIDTH, 10, width of AXI user fields
- MASTER_ID, 0, constant driven on axi_aw_id and axi_ar_id

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  master idle, request accepted on valid&ready
- req_we  in  1  1=write, 0=read
- req_addr  in  AXI_ADDR_WIDTH  byte address
- req_wdata  in  AXI_DATA_WIDTH  write data
- req_strb  in  AXI_STRB_WIDTH  write byte enables
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  AXI_DATA_WIDTH  read data, valid with rsp_valid on reads
- rsp_err  out  1  error flag, valid with rsp_valid
- axi_aw_*, axi_ar_*  out  (widths as the peripheral_spram_axi4 slave)  address channels; *_ready inputs
- axi_w_data/strb/last/user/valid  out  W channel; axi_w_ready in
- axi_b_id/resp/user/valid  in  B channel; axi_b_ready out
- axi_r_id/data/resp/last/user/valid  in  R channel; axi_r_ready out

Behaviour:
- Reset values:
  - All *_valid, axi_b_ready, axi_r_ready, rsp_valid and rsp_err are 0.
  - rsp_rdata and all AXI payload registers are 0.
  - State is IDLE, so req_ready is 1.
- Constant fields: len=0, size=log2(AXI_STRB_WIDTH), burst=INCR (2'b01), w_last=1. lock, cache, prot, qos, region and user are all 0.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA.
- req_ready is 1 only in IDLE. It is combinational from state.
- IDLE, request accepted with req_we=1:
  - Register addr, wdata and strb.
  - Next cycle assert axi_aw_valid and axi_w_valid together, then go to WR.
- IDLE, request accepted with req_we=0:
  - Register addr.
  - Assert axi_ar_valid, then go to RD_ADDR.
- WR:
  - Track aw_done and w_done independently.
  - Each valid drops the cycle after its own handshake and is never dropped before its handshake.
  - When both are done (same cycle or different cycles), go to WR_RESP with axi_b_ready=1.
- WR_RESP:
  - On axi_b_valid & axi_b_ready: pulse rsp_valid, set rsp_err = axi_b_resp[1], clear axi_b_ready, go to IDLE.
- RD_ADDR:
  - On axi_ar_ready: drop axi_ar_valid, set axi_r_ready=1, go to RD_DATA.
- RD_DATA:
  - On axi_r_valid & axi_r_ready: capture rsp_rdata = axi_r_data.
  - Set rsp_err = axi_r_resp[1] | ~axi_r_last.
  - Pulse rsp_valid, clear axi_r_ready, go to IDLE.
- Response IDs (axi_b_id, axi_r_id) are not checked; user fields are ignored.
- Latency with zero-wait slave: write is 3 cycles from accept to rsp_valid; read is 3 cycles.
- rsp_valid lasts exactly 1 cycle with no backpressure.
- A new request can be accepted in the cycle rsp_valid is high, because state is already IDLE.
- AXI payload signals stay stable while their valid is high.
- Reset asserted mid-transaction:
  - All outputs return to reset values immediately (asynchronous).
  - The in-flight request is dropped and no rsp_valid is issued.
- Address is passed through unmodified; alignment is the requester's responsibility.

Test Plan:
- Write addr=0x40, wdata=0xDEADBEEF_CAFEF00D, strb=0xFF, slave zero-wait, bresp=OKAY:
  - AW and W valid assert in the same cycle.
  - rsp_valid pulses once with rsp_err=0.
  - Then read addr=0x40: rsp_rdata=0xDEADBEEF_CAFEF00D, rsp_err=0.
- Write with axi_aw_ready delayed 3 cycles and axi_w_ready immediate:
  - w_valid drops after 1 cycle; aw_valid is held 4 cycles with stable addr.
  - Exactly one B handshake follows.
- Read with axi_r_resp=SLVERR (2'b10):
  - rsp_err=1, rsp_rdata = the driven axi_r_data.
- Read with axi_r_last=0 and resp=OKAY: rsp_err=1.
- Back-to-back: the next req_valid is held high while rsp_valid is high.
  - The second request is accepted in the same cycle rsp_valid pulses.
  - Both complete in order.
- rst_ni pulsed low while in WR_RESP:
  - All valids and axi_b_ready go to 0 asynchronously and no rsp_valid is issued.
  - req_ready=1 after reset release.
